// File: rtl/a2d_arb.sv
// Round-robin arbiter that shares one A2D converter among three requesters.
// Each grant runs START -> BUSY -> DONE; the conversion is timed out if cnv_cmplt never arrives.
module a2d_arb #(
  parameter logic FAST_SIM = 1'b1,
  localparam int  NUM_REQ  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [3*NUM_REQ-1:0] req_chnnl,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic                 tmo_err,
  output logic [11:0]          rslt,
  output logic                 strt_cnv,
  output logic [2:0]           chnnl,
  input  logic                 cnv_cmplt,
  input  logic [11:0]          res
);

  typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [2:0]           chnl_q, chnl_d;
  logic [1:0]           ptr_q, ptr_d;
  logic [15:0]          tmo_cnt_q, tmo_cnt_d;
  logic [11:0]          rslt_q, rslt_d;
  logic                 flag_q, flag_d;

  logic [1:0]           win_idx;
  logic [NUM_REQ-1:0]   win_oh;
  logic [2:0]           win_chnl;
  logic                 tmo_hit;

  // Search order starts at ptr and wraps 2->0; the result is only used when req != 0.
  always_comb begin
    win_idx = 2'd0;
    case (ptr_q)
      2'd1:    win_idx = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd2:    win_idx = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: win_idx = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_comb begin
    win_oh = 3'b001 << win_idx;
    case (win_idx)
      2'd1:    win_chnl = req_chnnl[5:3];
      2'd2:    win_chnl = req_chnnl[8:6];
      default: win_chnl = req_chnnl[2:0];
    endcase
  end

  assign tmo_hit = FAST_SIM ? (&tmo_cnt_q[10:0]) : (&tmo_cnt_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      chnl_q    <= 3'd0;
      ptr_q     <= 2'd0;
      tmo_cnt_q <= 16'd0;
      rslt_q    <= 12'h000;
      flag_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      chnl_q    <= chnl_d;
      ptr_q     <= ptr_d;
      tmo_cnt_q <= tmo_cnt_d;
      rslt_q    <= rslt_d;
      flag_q    <= flag_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    chnl_d    = chnl_q;
    ptr_d     = ptr_q;
    tmo_cnt_d = tmo_cnt_q;
    rslt_d    = rslt_q;
    flag_d    = flag_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d   = win_oh;
          chnl_d  = win_chnl;
          state_d = START;
        end
      end
      START: begin
        tmo_cnt_d = 16'd0;
        state_d   = BUSY;
      end
      BUSY: begin
        tmo_cnt_d = tmo_cnt_q + 16'd1;
        // A completion in the timeout cycle still counts as a good conversion.
        if (cnv_cmplt) begin
          rslt_d  = res;
          state_d = DONE;
        end else if (tmo_hit) begin
          flag_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        ptr_d   = gnt_q[0] ? 2'd1 : (gnt_q[1] ? 2'd2 : 2'd0);
        gnt_d   = '0;
        flag_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt      = gnt_q;
    rslt     = rslt_q;
    strt_cnv = (state_q == START);
    done     = (state_q == DONE) ? gnt_q : '0;
    tmo_err  = (state_q == DONE) && flag_q;
    chnnl    = (state_q == IDLE) ? 3'd0 : chnl_q;
  end

endmodule

// File: tb/tb_a2d_arb.sv
// Directed and randomized checks of a2d_arb against a transaction-level model
// (round-robin pointer, expected conversion length and held result).
module tb_a2d_arb;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req;
  logic [8:0]  req_chnnl;
  logic [2:0]  gnt;
  logic [2:0]  done;
  logic        tmo_err;
  logic [11:0] rslt;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic        cnv_cmplt;
  logic [11:0] res;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          m_ptr  = 0;
  logic [11:0] m_rslt = 12'h000;

  localparam int TMO_CYC = 2048;

  a2d_arb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_chnnl (req_chnnl),
    .gnt       (gnt),
    .done      (done),
    .tmo_err   (tmo_err),
    .rslt      (rslt),
    .strt_cnv  (strt_cnv),
    .chnnl     (chnnl),
    .cnv_cmplt (cnv_cmplt),
    .res       (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_gnt"}, gnt, 3'b000);
    chk({tag, "_done"}, done, 3'b000);
    chk({tag, "_tmo"}, tmo_err, 1'b0);
    chk({tag, "_strt"}, strt_cnv, 1'b0);
    chk({tag, "_chnnl"}, chnnl, 3'd0);
  endtask

  // One full arbitration: DUT must be IDLE on entry; returns in the IDLE cycle after done.
  // d = BUSY cycle index at which cnv_cmplt is pulsed (>= TMO_CYC means never).
  task automatic run_txn(input logic [2:0] r, input logic [8:0] chs, input int d,
                         input logic [11:0] rv, output int g);
    int          w;
    logic [1:0]  idx;
    logic [2:0]  ech;
    logic [2:0]  eoh;
    bit          timed_out;
    bit          got;
    int          busy_n;
    int          exp_busy;
    w = -1;
    for (int k = 0; k < 3; k++) begin
      idx = 2'((m_ptr + k) % 3);
      if (w < 0 && r[idx]) w = int'(idx);
    end
    if (w < 0) w = 0;
    ech = 3'(chs >> (3 * w));
    eoh = 3'(1 << w);
    timed_out = (d >= TMO_CYC);
    exp_busy  = timed_out ? TMO_CYC : d + 1;

    req = r; req_chnnl = chs; cnv_cmplt = 1'b0;
    wait_cycle();
    chk("grant_gnt", gnt, eoh);
    chk("grant_strt", strt_cnv, 1'b1);
    chk("grant_chnnl", chnnl, ech);
    chk("grant_done", done, 3'b000);

    // Inputs changed after grant must not matter; a completion during START is ignored.
    req_chnnl = 9'($urandom);
    req = 3'($urandom);
    cnv_cmplt = 1'b1;
    res = 12'($urandom);
    wait_cycle();
    cnv_cmplt = 1'b0;
    chk("busy_strt", strt_cnv, 1'b0);
    chk("busy_chnnl", chnnl, ech);

    got = 1'b0;
    busy_n = 0;
    while (!got && busy_n < TMO_CYC + 50) begin
      cnv_cmplt = (busy_n == d);
      res = (busy_n == d) ? rv : 12'($urandom);
      wait_cycle();
      cnv_cmplt = 1'b0;
      busy_n++;
      if (done != 3'b000) got = 1'b1;
      else if (busy_n % 64 == 1) begin
        chk("busy_gnt", gnt, eoh);
        chk("busy_chnnl_hold", chnnl, ech);
        chk("busy_strt_low", strt_cnv, 1'b0);
      end
    end
    chk("done_seen", got, 1'b1);
    chk("busy_len", busy_n, exp_busy);
    if (!timed_out) m_rslt = rv;
    chk("done_onehot", done, eoh);
    chk("done_tmo", tmo_err, timed_out);
    chk("done_rslt", rslt, m_rslt);
    chk("done_gnt", gnt, eoh);
    chk("done_chnnl", chnnl, ech);

    req = 3'b000;
    wait_cycle();
    chk_quiet("post_done");
    chk("post_done_rslt", rslt, m_rslt);
    m_ptr = (w + 1) % 3;
    g = w;
  endtask

  initial begin
    int g;
    req = 3'b000; req_chnnl = 9'd0; cnv_cmplt = 1'b0; res = 12'h000;
    rst_n = 1'b0;
    #1;
    chk_quiet("reset");
    chk("reset_rslt", rslt, 12'h000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycle();

    // Idle with no request, stray completion ignored
    cnv_cmplt = 1'b1; res = 12'h123;
    wait_cycle();
    cnv_cmplt = 1'b0;
    wait_cycle();
    chk_quiet("idle");
    chk("idle_rslt", rslt, 12'h000);

    // Single request on requester 1, channel 5, completion 20 cycles after strt_cnv
    run_txn(3'b010, {3'd0, 3'd5, 3'd0}, 19, 12'hA5C, g);
    chk("single_g", g, 1);

    // Channel stability on requester 0
    run_txn(3'b001, {3'd6, 3'd1, 3'd3}, 7, 12'h3C1, g);
    chk("stable_g", g, 0);

    // Timeout: no completion, result held
    run_txn(3'b100, {3'd4, 3'd0, 3'd0}, 100000, 12'hFFF, g);
    chk("tmo_g", g, 2);
    req = 3'b000;
    cnv_cmplt = 1'b1; res = 12'h777;
    wait_cycle();
    cnv_cmplt = 1'b0;
    repeat (3) wait_cycle();
    chk("late_cmplt_rslt", rslt, 12'h3C1);
    chk_quiet("late_cmplt");

    // Completion in the same cycle as the timeout
    run_txn(3'b011, {3'd0, 3'd2, 3'd7}, TMO_CYC - 1, 12'h5E5, g);
    chk("collide_g", g, 0);

    // Reset in the middle of BUSY
    req = 3'b100; req_chnnl = {3'd7, 3'd0, 3'd0};
    wait_cycle();
    req = 3'b000;
    repeat (6) wait_cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk_quiet("mid_reset");
    chk("mid_reset_rslt", rslt, 12'h000);
    m_ptr = 0; m_rslt = 12'h000;
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycle();
    cnv_cmplt = 1'b1; res = 12'hBAD;
    wait_cycle();
    cnv_cmplt = 1'b0;
    wait_cycle();
    chk_quiet("stray_cmplt");
    chk("stray_cmplt_rslt", rslt, 12'h000);

    // Fairness with all three requesting
    for (int k = 0; k < 6; k++) begin
      run_txn(3'b111, 9'($urandom), int'($urandom_range(0, 4)), 12'($urandom), g);
      chk("fair_order", g, k % 3);
    end

    // Randomized traffic
    for (int k = 0; k < 25; k++) begin
      run_txn(3'($urandom_range(1, 7)), 9'($urandom), int'($urandom_range(0, 40)),
              12'($urandom), g);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/a2d_arb.md
A2D_ARB -- requirements
Module: a2d_arb

Interface
REQ-001 Parameter FAST_SIM, default 1'b1: when 1, the timeout compare uses only tmo_cnt[10:0] (all ones); when 0, it uses all 16 bits.
REQ-002 Parameter NUM_REQ is fixed at 3; the requester index is 0..2 and it is not overridable.
REQ-003 clk  input  1  50MHz system clock; all flops are on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req  input  3  per-requester conversion request, level-sensitive.
REQ-006 req_chnnl  input  9  requested A2D channel, packed {ch2[2:0],ch1[2:0],ch0[2:0]}.
REQ-007 gnt  output  3  one-hot grant; 0 when idle.
REQ-008 done  output  3  one-hot, 1-cycle completion pulse to the granted requester.
REQ-009 tmo_err  output  1  1-cycle pulse, coincident with done, when the conversion timed out.
REQ-010 rslt  output  12  last completed conversion result, held until the next completion.
REQ-011 strt_cnv  output  1  1-cycle start pulse to the A2D interface.
REQ-012 chnnl  output  3  channel select to the A2D interface.
REQ-013 cnv_cmplt  input  1  conversion-complete pulse from the A2D interface.
REQ-014 res  input  12  conversion result from the A2D interface, valid when cnv_cmplt=1.

Function
REQ-015 The state machine SHALL have four states: IDLE, START, BUSY, DONE.
REQ-016 IDLE, with req!=0: the arbiter SHALL select a winner by round-robin and register gnt (one-hot) and the winner's channel into chnl_reg, then go to START.
REQ-017 Round-robin priority SHALL start at ptr and wrap 2->0, where ptr = (last granted index + 1) mod 3.
REQ-018 IDLE, with req==0: the arbiter SHALL stay in IDLE with gnt=0.
REQ-019 START: strt_cnv=1 for exactly this one cycle, tmo_cnt cleared, then go to BUSY; a grant-to-strt_cnv latency of 1 cycle.
REQ-020 chnnl SHALL equal chnl_reg in every state except IDLE, where it SHALL be 3'b000.
REQ-021 BUSY: tmo_cnt SHALL increment each cycle.
REQ-022 BUSY with cnv_cmplt=1: rslt<=res, then go to DONE.
REQ-023 BUSY, timeout reached without cnv_cmplt: rslt is unchanged, the error is flagged, then go to DONE.
REQ-024 If cnv_cmplt and timeout occur in the same cycle, cnv_cmplt SHALL win: no error, and rslt is loaded.
REQ-025 DONE: done[g]=1 for the granted index g and tmo_err=flag, both for one cycle.
REQ-026 DONE: ptr<=(g+1) mod 3, gnt<=0, the flag is cleared, then go to IDLE.
REQ-027 cnv_cmplt SHALL be ignored in IDLE, START and DONE; a late completion after a timeout SHALL NOT update rslt.
REQ-028 A request whose req and req_chnnl changes after grant SHALL NOT affect the conversion in flight; the channel is sampled only at grant.
REQ-029 A requester still holding req in the cycle after its done SHALL be treated as a new request, subject to round-robin.
REQ-030 The minimum spacing between two back-to-back grants SHALL be 4 cycles (IDLE->START->BUSY(>=1)->DONE).
REQ-031 gnt SHALL never have more than one bit set.

Reset
REQ-032 On rst_n=0, asynchronously: state=IDLE, gnt=0, done=0, tmo_err=0, strt_cnv=0, chnnl=0, rslt=12'h000, ptr=0, tmo_cnt=0, flag=0.
REQ-033 Reset asserted mid-conversion SHALL abandon the conversion; after release, a cnv_cmplt pulse arriving while IDLE SHALL be ignored.

Verification
REQ-034 Single request: req=3'b010, ch1=3'b101, res=12'hA5C with cnv_cmplt 20 cycles after strt_cnv -> gnt=3'b010, chnnl=5, strt_cnv one pulse, done=3'b010 one pulse, rslt=12'hA5C, tmo_err=0.
REQ-035 Fairness: req=3'b111 held continuously, completions returned promptly -> grant order 0,1,2,0,1,2, each done one-hot and never overlapping.
REQ-036 Timeout (FAST_SIM=1): no cnv_cmplt -> done and tmo_err pulse together after 2048 BUSY cycles; rslt unchanged; a later cnv_cmplt is ignored.
REQ-037 Collision: cnv_cmplt arrives in the same cycle the timeout is reached -> tmo_err=0, rslt=res.
REQ-038 Reset mid-BUSY: rst_n pulsed low -> all outputs 0 immediately; a subsequent stray cnv_cmplt leaves rslt=0 and done=0.
REQ-039 Channel stability: ch0 changed after grant -> chnnl holds the value sampled at grant until DONE.
